// File: rtl/smb_pkg.sv
// Shared definitions for the serial message bus transmitter and receiver.
package smb_pkg;

  // Transmitter frame sequencing states.
  typedef enum logic [2:0] {
    IDLE,
    START,
    ADDR,
    DATA,
    GAP
  } smb_tx_state_t;

  // Line level of the start bit that opens every frame.
  localparam logic SMB_START_BIT = 1'b0;
  // Line level between frames and after reset.
  localparam logic SMB_IDLE_LVL  = 1'b1;

  // Number of bit cycles in one frame: start bit, port field, data field.
  function automatic int smb_frame_len(input int port_w, input int data_w);
    return 1 + port_w + data_w;
  endfunction

endpackage

// File: rtl/smb_shift_reg.sv
// Loadable MSB-first parallel-in / serial-out register.
module smb_shift_reg #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_msb
);

  logic [WIDTH-1:0] r_bits;

  // Each bit either loads, takes its lower neighbour on a shift, or holds.
  // Zeros enter at the bottom so a drained register reads back as 0.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_bit
      logic w_below;
      if (gi == 0) begin : g_lsb
        assign w_below = 1'b0;
      end else begin : g_upper
        assign w_below = r_bits[gi-1];
      end

      // Per-bit storage: load wins over shift.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_bits[gi] <= 1'b0;
        end else if (i_load) begin
          r_bits[gi] <= i_data[gi];
        end else if (i_shift) begin
          r_bits[gi] <= w_below;
        end
      end
    end
  endgenerate

  assign o_msb = r_bits[WIDTH-1];

endmodule

// File: rtl/smb_serial_tx.sv
// Serial message bus transmitter: accepts one (port, data) message at a time
// and sends it as start bit, port field, data field, followed by an idle gap.
module smb_serial_tx #(
  parameter int PORT_W = 2,
  parameter int DATA_W = 4,
  parameter int GAP    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [PORT_W-1:0] tx_port,
  input  logic [DATA_W-1:0] tx_data,
  output logic              ser_out,
  output logic              busy,
  output logic              frame_done
);

  // Imported inside the body so the GAP parameter keeps its name; the GAP
  // state is always referenced with its package prefix.
  import smb_pkg::*;

  localparam int SR_W    = smb_frame_len(PORT_W, DATA_W) - 1;
  localparam int MAX_A   = (PORT_W > DATA_W) ? PORT_W : DATA_W;
  localparam int CNT_MAX = (MAX_A > GAP) ? MAX_A : GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // Counter reload values: each phase counts down to zero.
  localparam logic [CNT_W-1:0] C_PORT_LAST = CNT_W'(PORT_W - 1);
  localparam logic [CNT_W-1:0] C_DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] C_GAP_LAST  = (GAP > 0) ? CNT_W'(GAP - 1) : '0;

  smb_tx_state_t    r_state;
  smb_tx_state_t    r_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_cnt_next;
  logic             r_ser;
  logic             r_ser_next;
  logic             w_load;
  logic             w_shift;
  logic             w_msb;

  smb_shift_reg #(
    .WIDTH (SR_W)
  ) u_shift (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_data  ({tx_port, tx_data}),
    .o_msb   (w_msb)
  );

  // State, bit counter and registered line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ser   <= SMB_IDLE_LVL;
    end else begin
      r_state <= r_state_next;
      r_cnt   <= r_cnt_next;
      r_ser   <= r_ser_next;
    end
  end

  // Next state plus the line level for the next cycle. The line register is
  // loaded one edge ahead, so the bit leaving the shift register here is the
  // one shown while the FSM sits in the following state.
  always_comb begin
    r_state_next = r_state;
    r_cnt_next   = r_cnt;
    r_ser_next   = SMB_IDLE_LVL;
    w_load       = 1'b0;
    w_shift      = 1'b0;
    case (r_state)
      IDLE: begin
        if (tx_valid) begin
          r_state_next = START;
          w_load       = 1'b1;
          r_ser_next   = SMB_START_BIT;
        end
      end
      START: begin
        r_state_next = ADDR;
        r_cnt_next   = C_PORT_LAST;
        r_ser_next   = w_msb;
        w_shift      = 1'b1;
      end
      ADDR: begin
        r_ser_next = w_msb;
        w_shift    = 1'b1;
        if (r_cnt == '0) begin
          r_state_next = DATA;
          r_cnt_next   = C_DATA_LAST;
        end else begin
          r_cnt_next = r_cnt - 1'b1;
        end
      end
      DATA: begin
        if (r_cnt == '0) begin
          r_cnt_next = C_GAP_LAST;
          if (GAP > 0) begin
            r_state_next = smb_pkg::GAP;
          end else begin
            r_state_next = IDLE;
          end
        end else begin
          r_ser_next = w_msb;
          w_shift    = 1'b1;
          r_cnt_next = r_cnt - 1'b1;
        end
      end
      smb_pkg::GAP: begin
        if (r_cnt == '0) begin
          r_state_next = IDLE;
        end else begin
          r_cnt_next = r_cnt - 1'b1;
        end
      end
      default: begin
        r_state_next = IDLE;
        r_cnt_next   = '0;
      end
    endcase
  end

  // Ready is held low during reset even though the state already reads IDLE.
  assign tx_ready   = (r_state == IDLE) && !rst;
  assign busy       = (r_state != IDLE);
  assign frame_done = (r_state == DATA) && (r_cnt == '0);
  assign ser_out    = r_ser;

endmodule

// File: tb/tb_smb_serial_tx.sv
// Self-checking bench for smb_serial_tx: queue-based line model, behavioural
// receiver scoreboard, directed literal frames and randomized traffic.
module tb_smb_serial_tx;

  localparam int PW     = 2;
  localparam int DW     = 4;
  localparam int TB_GAP = 2;

  logic          clk;
  logic          rst;
  logic          tx_valid;
  logic          tx_ready;
  logic [PW-1:0] tx_port;
  logic [DW-1:0] tx_data;
  logic          ser_out;
  logic          busy;
  logic          frame_done;

  logic          tx_valid0;
  logic          tx_ready0;
  logic [PW-1:0] tx_port0;
  logic [DW-1:0] tx_data0;
  logic          ser_out0;
  logic          busy0;
  logic          frame_done0;

  int total = 0;
  int bad   = 0;

  smb_serial_tx #(.PORT_W(PW), .DATA_W(DW), .GAP(TB_GAP)) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_port    (tx_port),
    .tx_data    (tx_data),
    .ser_out    (ser_out),
    .busy       (busy),
    .frame_done (frame_done)
  );

  smb_serial_tx #(.PORT_W(PW), .DATA_W(DW), .GAP(0)) dut0 (
    .clk        (clk),
    .rst        (rst),
    .tx_valid   (tx_valid0),
    .tx_ready   (tx_ready0),
    .tx_port    (tx_port0),
    .tx_data    (tx_data0),
    .ser_out    (ser_out0),
    .busy       (busy0),
    .frame_done (frame_done0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Line model: one queue entry per bit cycle still owed by the current frame.
  typedef struct {
    bit b;
    bit d;
  } item_t;
  item_t        q[$];
  logic [5:0]   expf[$];

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        q.delete();
        expf.delete();
      end else if (q.size() > 0) begin
        void'(q.pop_front());
      end else if (tx_valid) begin
        q.push_back('{b: 1'b0, d: 1'b0});
        for (int i = PW - 1; i >= 0; i--) q.push_back('{b: tx_port[i], d: 1'b0});
        for (int i = DW - 1; i >= 0; i--) q.push_back('{b: tx_data[i], d: (i == 0)});
        for (int i = 0; i < TB_GAP; i++) q.push_back('{b: 1'b1, d: 1'b0});
        expf.push_back({tx_port, tx_data});
      end
    end
  end

  // Every-cycle comparison against the line model.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("ser_out", {31'd0, ser_out}, {31'd0, (q.size() > 0) ? q[0].b : 1'b1});
        chk("tx_ready", {31'd0, tx_ready}, {31'd0, q.size() == 0});
        chk("busy", {31'd0, busy}, {31'd0, q.size() != 0});
        chk("frame_done", {31'd0, frame_done}, {31'd0, (q.size() > 0) ? q[0].d : 1'b0});
      end
    end
  end

  // Behavioural receiver fed from ser_out: routes data to ports and
  // scoreboards every decoded frame against the accepted messages.
  logic [DW-1:0] pl[4];
  int            frames = 0;
  int            done_cnt = 0;
  bit            rx_in;
  int            rx_k;
  logic [5:0]    rx_sh;

  initial begin
    rx_in = 0;
    rx_k  = 0;
    rx_sh = '0;
    forever begin
      @(negedge clk or posedge rst);
      if (rst) begin
        rx_in = 0;
        rx_k  = 0;
      end else if (clk == 1'b0) begin
        if (frame_done) done_cnt++;
        if (!rx_in) begin
          if (ser_out == 1'b0) begin
            rx_in = 1;
            rx_k  = 0;
            rx_sh = '0;
          end
        end else begin
          rx_sh = {rx_sh[4:0], ser_out};
          rx_k++;
          if (rx_k == PW + DW) begin
            rx_in = 0;
            pl[rx_sh[5:4]] = rx_sh[3:0];
            frames++;
            if (expf.size() == 0) begin
              chk("rx_unexpected", {26'd0, rx_sh}, 32'hFFFF_FFFF);
            end else begin
              chk("rx_frame", {26'd0, rx_sh}, {26'd0, expf.pop_front()});
            end
          end
        end
      end
    end
  end

  // Offer a message and hold it until accepted; returns 1 ns after the
  // accepting edge. With keep=0 valid drops and the inputs become garbage.
  task automatic send(input logic [PW-1:0] p, input logic [DW-1:0] d, input bit keep);
    int n;
    bit acc;
    n   = 0;
    acc = 0;
    tx_port  = p;
    tx_data  = d;
    tx_valid = 1'b1;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = tx_ready;
      @(posedge clk);
      #1;
      n++;
    end
    chk("send_accept", {31'd0, acc}, 32'd1);
    if (!keep) begin
      tx_valid = 1'b0;
      tx_port  = PW'($urandom);
      tx_data  = DW'($urandom);
    end
  endtask

  task automatic capture(input int n, output logic [31:0] vs, output logic [31:0] vd,
                         output logic [31:0] vr);
    vs = '0;
    vd = '0;
    vr = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      vs = {vs[30:0], ser_out};
      vd = {vd[30:0], frame_done};
      vr = {vr[30:0], tx_ready};
    end
  endtask

  task automatic drain(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [31:0] vs, vd, vr;
  int          fc, fdc, n0;
  logic [31:0] s0, r0;

  initial begin
    rst       = 1'b1;
    tx_valid  = 1'b0;
    tx_port   = '0;
    tx_data   = '0;
    tx_valid0 = 1'b0;
    tx_port0  = 2'b01;
    tx_data0  = 4'b0101;
    for (int k = 0; k < 4; k++) pl[k] = 4'hF;

    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    drain(2);

    // Reset asserted mid-cycle while idle.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_ser_out", {31'd0, ser_out}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, tx_ready}, 32'd0);
    chk("rst_done", {31'd0, frame_done}, 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_ready", {31'd0, tx_ready}, 32'd1);

    // Single frame: port 10, data 1010.
    send(2'b10, 4'b1010, 1'b0);
    capture(10, vs, vd, vr);
    chk("single_bits", vs & 32'h3FF, 32'b0101010111);
    chk("single_done", vd & 32'h3FF, 32'b0000001000);
    chk("single_ready", vr & 32'h3FF, 32'b0000000001);
    drain(1);

    // Back-to-back frames with valid held.
    for (int k = 0; k < 4; k++) pl[k] = 4'hF;
    send(2'b00, 4'b0000, 1'b1);
    fork
      send(2'b11, 4'b0001, 1'b0);
      capture(17, vs, vd, vr);
    join
    chk("b2b_bits", vs & 32'h1FFFF, 32'b00000001110110001);
    drain(12);
    chk("b2b_pl0", {28'd0, pl[0]}, 32'h0);
    chk("b2b_pl3", {28'd0, pl[3]}, 32'h1);

    // Back-pressure: a one-cycle valid pulse during DATA is not captured.
    fc = frames;
    send(2'b10, 4'b0011, 1'b0);
    fork
      capture(10, vs, vd, vr);
      begin
        drain(3);
        tx_port  = 2'b01;
        tx_data  = 4'b1100;
        tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_valid = 1'b0;
      end
    join
    chk("bp_bits", vs & 32'h3FF, 32'b0100011111);
    chk("bp_ready", vr & 32'h3FF, 32'b0000000001);
    drain(1);
    send(2'b01, 4'b1100, 1'b0);
    drain(12);
    chk("bp_frames", frames, fc + 2);
    chk("bp_pl1", {28'd0, pl[1]}, 32'hC);

    // Reset during the second port bit.
    fc  = frames;
    fdc = done_cnt;
    send(2'b10, 4'b1001, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("mid_bit_before_rst", {31'd0, ser_out}, 32'd0);
    rst = 1'b1;
    #1;
    chk("mid_rst_ser_out", {31'd0, ser_out}, 32'd1);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    drain(10);
    chk("mid_no_done", done_cnt, fdc);
    chk("mid_no_frame", frames, fc);
    send(2'b10, 4'b0110, 1'b0);
    drain(12);
    chk("mid_frames", frames, fc + 1);
    chk("mid_pl2", {28'd0, pl[2]}, 32'h6);

    // GAP=0 instance with valid held: exactly one idle cycle between frames.
    tx_valid0 = 1'b1;
    n0 = 0;
    do begin
      @(negedge clk);
      n0++;
    end while (!frame_done0 && n0 < 60);
    chk("gap0_done_seen", {31'd0, frame_done0}, 32'd1);
    s0 = '0;
    r0 = '0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      s0 = {s0[30:0], ser_out0};
      r0 = {r0[30:0], tx_ready0};
    end
    chk("gap0_bits", s0 & 32'h1FF, 32'b100101011);
    chk("gap0_ready", r0 & 32'h1FF, 32'b100000001);
    tx_valid0 = 1'b0;
    @(posedge clk);
    #1;

    // Randomized traffic, checked by the line model and receiver scoreboard.
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      send(PW'($urandom), DW'($urandom), bit'($urandom_range(0, 1)));
    end
    tx_valid = 1'b0;
    drain(20);
    chk("rand_scoreboard_empty", expf.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit in case a wait never resolves.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
